// File: rtl/lfsr9_pkg.sv
// Shared definitions for the 8-bit XNOR LFSR used by the mapper/unmapper.
// Provides the FSM state type, tap mask, step limit and the step function.
package lfsr9_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_e;

    // Feedback taps: bits 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS    = 8'b1011_1000;
    // Last step count that is still compared before declaring a miss.
    localparam logic [7:0] LFSR_MAXSTEP = 8'd254;
    localparam logic [7:0] INDEX_MISS   = 8'hFF;

    // One XNOR LFSR step; 8'hFF is the lockup state.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic fb;
        fb = ~^(s & LFSR_TAPS);
        return {s[6:0], fb};
    endfunction

endpackage

// File: rtl/lfsr8_xnor.sv
// 8-bit XNOR LFSR register with synchronous load-to-seed and step enables.
// Ports: clk_i, rst_i (async high), load_i (q <= SEED), step_i, q_o state.
module lfsr8_xnor
    import lfsr9_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] q_o
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Load wins over step so a restart always begins at the seed.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = SEED;
        end else if (step_i) begin
            q_d = lfsr_step(q_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/lfsr_unmap9.sv
// Inverse LFSR mapper: steps the LFSR from SEED until it equals target and
// reports the step count. Ports: clock, reset (async high), start, target,
// index, done (held until next start), miss, busy, sr (LFSR state).
module lfsr_unmap9
    import lfsr9_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] target,
    output logic [7:0] index,
    output logic       done,
    output logic       miss,
    output logic       busy,
    output logic [7:0] sr
);

    state_e     state_q, state_d;
    logic       sb0_q, sb1_q;
    logic [7:0] tgt_q, tgt_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] index_q, index_d;
    logic       done_q, done_d;
    logic       miss_q, miss_d;
    logic       lfsr_load;
    logic       lfsr_step_en;
    logic [7:0] sr_w;
    logic       start_edge;

    lfsr8_xnor #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (lfsr_load),
        .step_i (lfsr_step_en),
        .q_o    (sr_w)
    );

    // Two-flop synchroniser; a held start yields one edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb0_q <= 1'b0;
            sb1_q <= 1'b0;
        end else begin
            sb0_q <= start;
            sb1_q <= sb0_q;
        end
    end

    assign start_edge = sb0_q & ~sb1_q;

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        cnt_d        = cnt_q;
        index_d      = index_q;
        done_d       = done_q;
        miss_d       = miss_q;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    tgt_d     = target;
                    cnt_d     = 8'd0;
                    done_d    = 1'b0;
                    miss_d    = 1'b0;
                    lfsr_load = 1'b1;
                    state_d   = SEARCH;
                end
            end
            SEARCH: begin
                // Match has priority so step 254 is still reachable.
                if (sr_w == tgt_q) begin
                    index_d = cnt_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == LFSR_MAXSTEP) begin
                    index_d = INDEX_MISS;
                    miss_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    lfsr_step_en = 1'b1;
                    cnt_d        = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= 8'h00;
            cnt_q   <= 8'h00;
            index_q <= 8'h00;
            done_q  <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
        end
    end

    assign index = index_q;
    assign done  = done_q;
    assign miss  = miss_q;
    assign busy  = (state_q == SEARCH);
    assign sr    = sr_w;

endmodule

// File: tb/tb_lfsr_unmap9.sv
// Self-checking bench for lfsr_unmap9: scoreboard of expected index/miss,
// latency and busy-length checks, restart, reset-mid-search, held start.
module tb_lfsr_unmap9;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] target;
    logic [7:0] index;
    logic       done;
    logic       miss;
    logic       busy;
    logic [7:0] sr;

    typedef struct packed {
        logic [7:0] idx;
        logic       mis;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    lfsr_unmap9 #(
        .SEED (8'h00)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .target (target),
        .index  (index),
        .done   (done),
        .miss   (miss),
        .busy   (busy),
        .sr     (sr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] m_step(input logic [7:0] s);
        return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
    endfunction

    // Pulse/hold start and wait for the result. lat counts rising edges
    // from the start launch up to the edge on which done appears.
    task automatic run_search(input logic [7:0] tgt, input int hold,
                              input int repulse, output int lat,
                              output int bcnt, output bit tmo);
        lat  = 0;
        bcnt = 0;
        tmo  = 1'b1;
        @(negedge clock);
        target = tgt;
        start  = 1'b1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clock);
            if (cyc >= hold) start = 1'b0;
            if (repulse != 0 && cyc == repulse) start = 1'b1;
            if (busy) bcnt++;
            if (cyc >= 3 && done) begin
                lat = cyc;
                tmo = 1'b0;
                break;
            end
        end
        start = 1'b0;
        if (tmo) begin
            checks++;
            $display("FAIL timeout tgt=%02h: done never rose", tgt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        target = 8'h00;
        repeat (2) @(negedge clock);
        checks++;
        if ({index, done, miss, busy, sr} !== {8'h00, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset: idx=%02h done=%b miss=%b busy=%b sr=%02h",
                     index, done, miss, busy, sr);
        else passed++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Single search with scoreboard compare of index, miss, latency, busy.
    task automatic test_target(input logic [7:0] tgt, input logic [7:0] k,
                               input logic m, input int repulse);
        exp_t e;
        int   lat, bcnt;
        bit   tmo;
        exp_q.push_back('{idx: k, mis: m, lat: 3 + (m ? 254 : int'(k))});
        run_search(tgt, 1, repulse, lat, bcnt, tmo);
        e = exp_q.pop_front();
        if (tmo) return;
        checks++;
        if (index !== e.idx || miss !== e.mis || done !== 1'b1)
            $display("FAIL result tgt=%02h: idx=%02h miss=%b want %02h/%b",
                     tgt, index, miss, e.idx, e.mis);
        else passed++;
        checks++;
        if (lat !== e.lat)
            $display("FAIL latency tgt=%02h: got %0d want %0d", tgt, lat, e.lat);
        else passed++;
        checks++;
        if (bcnt !== e.lat - 2 || busy !== 1'b0)
            $display("FAIL busy tgt=%02h: cycles %0d want %0d busy=%b",
                     tgt, bcnt, e.lat - 2, busy);
        else passed++;
    endtask

    task automatic test_ignored_start();
        // Re-pulse sampled at C+3; result must be unaffected.
        test_target(8'h3D, 8'd6, 1'b0, 4);
        repeat (6) @(negedge clock);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || index !== 8'd6)
            $display("FAIL ignored_start: done=%b busy=%b idx=%02h want 1/0/06",
                     done, busy, index);
        else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        target = 8'h1E;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sr !== 8'h00 || miss !== 1'b0)
            $display("FAIL reset_mid: done=%b busy=%b sr=%02h miss=%b",
                     done, busy, sr, miss);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_target(8'h1E, 8'd5, 1'b0, 0);
    endtask

    task automatic test_all_targets();
        logic [7:0] s;
        int         bad;
        int         lat, bcnt;
        bit         tmo;
        exp_t       e;
        s   = 8'h00;
        bad = 0;
        for (int k = 0; k < 255; k++) begin
            exp_q.push_back('{idx: k[7:0], mis: 1'b0, lat: 3 + k});
            run_search(s, 1, 0, lat, bcnt, tmo);
            e = exp_q.pop_front();
            if (!tmo && (index !== e.idx || miss !== 1'b0 || lat !== e.lat)) begin
                bad++;
                if (bad < 5)
                    $display("FAIL sweep tgt=%02h: idx=%02h lat=%0d want %02h/%0d",
                             s, index, lat, e.idx, e.lat);
            end
            s = m_step(s);
        end
        checks++;
        if (bad !== 0 || s !== 8'h00)
            $display("FAIL sweep_total: %0d bad, end state %02h want 0/00", bad, s);
        else passed++;
    endtask

    task automatic test_held_start();
        int   lat, bcnt, rises;
        bit   tmo, prev;
        exp_t e;
        exp_q.push_back('{idx: 8'd6, mis: 1'b0, lat: 9});
        run_search(8'h3D, 10, 0, lat, bcnt, tmo);
        e = exp_q.pop_front();
        rises = 0;
        prev  = busy;
        // start stays high through cycle 10 in run_search only if not done;
        // hold it explicitly here for the remainder of the 10 cycles.
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i >= 1) start = 1'b0;
            if (busy && !prev) rises++;
            prev = busy;
        end
        checks++;
        if (tmo || index !== e.idx || lat !== e.lat || rises !== 0 || done !== 1'b1)
            $display("FAIL held_start: idx=%02h lat=%0d extra=%0d done=%b",
                     index, lat, rises, done);
        else passed++;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        target = 8'h00;
        test_reset();
        test_target(8'h00, 8'd0, 1'b0, 0);
        test_target(8'h3D, 8'd6, 1'b0, 0);
        test_target(8'hFF, 8'hFF, 1'b1, 0);
        test_target(8'h07, 8'd3, 1'b0, 0);
        test_ignored_start();
        test_reset_mid();
        test_held_start();
        test_all_targets();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_unmap9.md
# lfsr_unmap9

Inverse companion to the `map9v3` LFSR mapper. Given a target 8-bit state of the shared XNOR LFSR, it steps the LFSR from its seed until it reaches the target and reports the step count `k` as `index`. The host can then recover the mapper operand that produced that state. It sits beside the mapper on the same start/done control bus and uses the same start synchroniser and done-hold convention.

## Interface
Parameters:
- `SEED`, default 8'h00: LFSR state at step 0; must match the mapper seed.

Ports (clock and reset first):
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: request, asynchronous to logic; double-registered internally.
- `target` in 8: LFSR state to search for; sampled on the capture cycle only.
- `index` out 8: step count `k` at match; `8'hFF` on miss.
- `done` out 1: result valid; held high until the next accepted start.
- `miss` out 1: target not reachable within 255 steps. Valid while `done` is high.
- `busy` out 1: high in SEARCH.
- `sr` out 8: current LFSR state, for observability.

## Operation
- LFSR step: `sr_next = {sr[6:0], ~(sr[7]^sr[5]^sr[4]^sr[3])}`.
  - XNOR form; period 255.
  - 8'hFF is the lockup state and is never visited from seed 0.
- Start synchroniser: `sb0 <= start`, `sb1 <= sb0`. Edge = `sb0 & ~sb1`.
- States:
  - IDLE:
    - On edge: latch `target`, `sr <= SEED`, `cnt <= 0`, `done <= 0`, `miss <= 0`, go to SEARCH.
  - SEARCH (checked in priority order):
    1. If `sr == tgt`: `index <= cnt`, `done <= 1`, go to IDLE.
    2. Else if `cnt == 254`: `index <= 8'hFF`, `miss <= 1`, `done <= 1`, go to IDLE.
    3. Else: step `sr`, `cnt <= cnt + 1`.
- Start edges during SEARCH are ignored; there is no queueing.
- Start edge while `done` is high (IDLE): restart. `done` and `miss` drop on the capture cycle.
- `cnt` is 8 bits and never wraps; the miss check fires first.
- Reset values: `sr = SEED`, `index = 0`, `done = 0`, `miss = 0`, `busy = 0`, state = IDLE, `sb0 = sb1 = 0`.
- Reset mid-search: everything clears asynchronously. No result is produced, and the next start begins a fresh search.

## Timing
- Capture edge C is the first rising edge where `sb0 = 1` and `sb1 = 0`. That is the second edge after `start` rises and is met at setup.
- `target` must be stable at C; later changes are ignored.
- Match at step `k`: `done` and `index` valid after edge C+k+1. Latency is therefore k+1 cycles after capture, 3+k from `start`.
- Miss: `done` and `miss` rise after edge C+255.
- `busy` is high from after C through the edge on which `done` rises. `busy` and `done` are never high together.
- `start` must be low for at least 1 sampled cycle between requests. A `start` held high produces a single request.

## Structure
- Package `lfsr9_pkg`:
  - state enum `{IDLE, SEARCH}`
  - `LFSR_TAPS = 8'b1011_1000`
  - `LFSR_MAXSTEP = 8'd254`
  - function `lfsr_step(logic [7:0])`, shared with the mapper
- One natural sub-module: `lfsr8_xnor`. It holds the register with load/step enables and `SEED`, and is reusable by the mapper.
- Start synchroniser and FSM live inline.

## Test plan
- Reset, then `target = 8'h00` and pulse `start` → after C+1: `index = 0`, `done = 1`, `miss = 0`.
- `target = 8'h3D` → sequence 00, 01, 03, 07, 0F, 1E, 3D; `index = 6` and `done` rises after C+7.
- `target = 8'hFF` → `busy` for 255 cycles, then `done = 1`, `miss = 1`, `index = 8'hFF`.
- `start` pulsed again at C+3 during a search for 8'h3D → ignored; result is still `index = 6` at C+7.
- `reset` asserted at C+3 while searching for 8'h1E → `done = 0`, `busy = 0`, `sr = 00` immediately. A fresh start then gives `index = 5`.
- For all 255 reachable targets, drive the `map9v3` output `sr` into `target` → `index` equals the mapper step count. `start` held high for 10 cycles → exactly one search.
